// File: rtl/bidir_bus_port_pkg.sv
// Shared types and constants for the cartridge data-bus port.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
//
// Contents:
//   bus_state_t : direction FSM states
//   CNT_W       : width of the turnaround dead-cycle counter
//   params_ok() : range check for the port parameters
package bidir_bus_pkg;

  typedef enum logic [1:0] {
    HIZ      = 2'd0,
    TURN_OUT = 2'd1,
    DRIVE    = 2'd2,
    TURN_IN  = 2'd3
  } bus_state_t;

  localparam int CNT_W = 4;

  function automatic bit params_ok(int width, int sync_stages, int turn_cycles, int stb_filter);
    return (width >= 1) && (width <= 32) &&
           (sync_stages >= 2) &&
           (turn_cycles >= 0) && (turn_cycles <= 15) &&
           (stb_filter >= 1) && (stb_filter <= 8);
  endfunction

endpackage

// File: rtl/bidir_bus_port_if.sv
// Logic-side signal bundle of the cartridge bus port.
// Latency: n/a (wires only).
// Backpressure: none; drive_en is a level request and cap_valid is a single-cycle pulse.
//
// master : cartridge bus logic (drives drive_en/drive_data, forwards strobe_n)
// slave  : bidir_bus_port (returns rd_data, capture and status)
interface bidir_bus_port_if #(
  parameter int WIDTH = 8
);
  logic             drive_en;
  logic [WIDTH-1:0] drive_data;
  logic             strobe_n;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] cap_data;
  logic             cap_valid;
  logic             bus_dir;
  logic             busy;

  modport master (
    output drive_en, drive_data, strobe_n,
    input  rd_data, cap_data, cap_valid, bus_dir, busy
  );

  modport slave (
    input  drive_en, drive_data, strobe_n,
    output rd_data, cap_data, cap_valid, bus_dir, busy
  );
endinterface

// File: rtl/io_pad_cell.sv
// One-bit registered tristate I/O cell.
// Latency: 1 cycle pad->d_in, 1 cycle oe/d_out->pad.
// Backpressure: none.
//
// Ports: clk, d_in (registered pad value), d_out (data to drive),
//        oe (output enable, registered in the cell), pad (package pin).
module io_pad_cell (
  input  logic clk,
  output logic d_in,
  input  logic d_out,
  input  logic oe,
  inout  wire  pad
);

`ifdef USE_RADIANT
  logic pad_i;
  logic pad_o;
  logic pad_t;

  IOL_B #(
    .LATCHIN ("NONE_REG"),
    .DDROUT  ("NO")
  ) u_iol (
    .PADDI  (pad_i),
    .DO1    (1'b0),
    .DO0    (d_out),
    .CE     (1'b1),
    .IOLTO  (~oe),
    .HOLD   (1'b0),
    .INCLK  (clk),
    .OUTCLK (clk),
    .PADDO  (pad_o),
    .PADDT  (pad_t),
    .DI1    (),
    .DI0    (d_in)
  );

  BB_B u_bb (
    .T_N (pad_t),
    .I   (pad_o),
    .O   (pad_i),
    .B   (pad)
  );
`elsif USE_ICE40
  // Registered output, registered output enable, registered input.
  SB_IO #(
    .PIN_TYPE (6'b1101_00),
    .PULLUP   (1'b0)
  ) u_io (
    .PACKAGE_PIN   (pad),
    .CLOCK_ENABLE  (1'b1),
    .INPUT_CLK     (clk),
    .OUTPUT_CLK    (clk),
    .OUTPUT_ENABLE (oe),
    .D_OUT_0       (d_out),
    .D_IN_0        (d_in)
  );
`else
  // Behavioural equivalent of the registered cell; the cell flops carry no reset,
  // the top forces oe low while rst is held.
  logic oe_q;
  logic do_q;
  logic di_q;

  always_ff @(posedge clk) begin
    oe_q <= oe;
    do_q <= d_out;
    di_q <= pad;
  end

  assign pad  = oe_q ? do_q : 1'bz;
  assign d_in = di_q;
`endif

endmodule

// File: rtl/bidir_bus_port.sv
// Bidirectional cartridge data-bus port: direction FSM with turnaround dead cycles,
// input synchroniser, deglitched write strobe and strobe-aligned word capture.
// Latency: pad->rd_data SYNC_STAGES cycles; drive_en->pad TURN_CYCLES+1 edges after acceptance.
// Backpressure: none; busy flags turnaround, drive_en is ignored during TURN_IN.
//
// Ports: clk, rst (sync, active-high), bus (slave modport: drive_en, drive_data,
//        strobe_n, rd_data, cap_data, cap_valid, bus_dir, busy), pad[WIDTH].
module bidir_bus_port
  import bidir_bus_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 1,
  parameter int STB_FILTER  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  bidir_bus_port_if.slave        bus,
  inout  wire  [WIDTH-1:0]       pad
);

  if (!params_ok(WIDTH, SYNC_STAGES, TURN_CYCLES, STB_FILTER)) begin : g_param_err
    $error("bidir_bus_port: parameter out of range");
  end

  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [2:0]       FLT_LAST  = 3'(STB_FILTER - 1);

  // ---------------- direction FSM ----------------
  bus_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             oe_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HIZ;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      HIZ: begin
        if (bus.drive_en) begin
          if (TURN_CYCLES == 0) begin
            state_nxt = DRIVE;
          end else begin
            state_nxt = TURN_OUT;
            cnt_nxt   = TURN_LOAD;
          end
        end
      end
      TURN_OUT: begin
        // Dropping the request mid-turnaround aborts straight back to hi-Z.
        if (!bus.drive_en)    state_nxt = HIZ;
        else if (cnt == '0)   state_nxt = DRIVE;
        else                  cnt_nxt   = cnt - CNT_W'(1);
      end
      DRIVE: begin
        if (!bus.drive_en) begin
          if (TURN_CYCLES == 0) begin
            state_nxt = HIZ;
          end else begin
            state_nxt = TURN_IN;
            cnt_nxt   = TURN_LOAD;
          end
        end
      end
      TURN_IN: begin
        // The inbound turnaround always completes; drive_en is not looked at here.
        if (cnt == '0) state_nxt = HIZ;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = HIZ;
    endcase
  end

  always_comb begin
    bus.bus_dir = (state == DRIVE);
    bus.busy    = (state == TURN_OUT) || (state == TURN_IN);
    // rst gates oe combinationally so the pad releases on the first reset edge.
    oe_req      = (state == DRIVE) && !rst;
  end

  // ---------------- I/O cells ----------------
  logic [WIDTH-1:0] pad_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    io_pad_cell u_cell (
      .clk   (clk),
      .d_in  (pad_in[i]),
      .d_out (bus.drive_data[i]),
      .oe    (oe_req),
      .pad   (pad[i])
    );
  end

  // ---------------- input synchroniser ----------------
  // The cell input register is the first stage; SYNC_STAGES-1 more follow here.
  logic [WIDTH-1:0] rd_sync [SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES - 1; i++) rd_sync[i] <= '0;
    end else begin
      rd_sync[0] <= pad_in;
      for (int i = 1; i < SYNC_STAGES - 1; i++) rd_sync[i] <= rd_sync[i-1];
    end
  end

  assign bus.rd_data = rd_sync[SYNC_STAGES-2];

  // ---------------- strobe synchroniser and filter ----------------
  // Same depth as the data path, so stb_s and rd_data describe the same pad cycle.
  logic [SYNC_STAGES-1:0] stb_sync;
  logic                   stb_s;
  logic                   stb_flt;
  logic [2:0]             flt_cnt;
  logic                   flt_flip;
  logic                   stb_rise;

  always_ff @(posedge clk) begin
    if (rst) stb_sync <= '1;
    else     stb_sync <= {stb_sync[SYNC_STAGES-2:0], bus.strobe_n};
  end

  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign flt_flip = (stb_s != stb_flt) && (flt_cnt == FLT_LAST);
  assign stb_rise = flt_flip && stb_s;

  // flt_cnt counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_flt <= 1'b1;
      flt_cnt <= '0;
    end else if (stb_s == stb_flt) begin
      flt_cnt <= '0;
    end else if (flt_flip) begin
      stb_flt <= stb_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 3'd1;
    end
  end

  // ---------------- delay line and capture ----------------
  // The filter accepts the rise STB_FILTER samples after the last low sample, so a
  // STB_FILTER-deep delay on rd_data presents the word from that last low cycle.
  logic [WIDTH-1:0] dly [STB_FILTER];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STB_FILTER; i++) dly[i] <= '0;
    end else begin
      dly[0] <= bus.rd_data;
      for (int i = 1; i < STB_FILTER; i++) dly[i] <= dly[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cap_data  <= '0;
      bus.cap_valid <= 1'b0;
    end else begin
      bus.cap_valid <= stb_rise && (state == HIZ);
      if (stb_rise && (state == HIZ)) bus.cap_data <= dly[STB_FILTER-1];
    end
  end

endmodule

// File: tb/tb_bidir_bus_port.sv
// Self-checking bench for bidir_bus_port: reset, direction FSM vectors for
// TURN_CYCLES 1/3/0, capture/glitch/drive-blocking sequences and a randomized
// input/capture run against a history-based reference model.
`timescale 1ns/1ps
module tb_bidir_bus_port;
  localparam int W = 8;
  localparam int S = 2;
  localparam int F = 2;
  localparam int N = 600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bidir_bus_port_if #(.WIDTH(W)) bus_a ();
  bidir_bus_port_if #(.WIDTH(W)) bus_b ();
  bidir_bus_port_if #(.WIDTH(W)) bus_c ();

  wire  [W-1:0] pad_a;
  wire  [W-1:0] pad_b;
  wire  [W-1:0] pad_c;
  logic         tb_pad_oe;
  logic [W-1:0] tb_pad_val;

  assign pad_a = tb_pad_oe ? tb_pad_val : 'z;

  // Released pads float high, so a released pad reads all ones.
  for (genvar i = 0; i < W; i++) begin : g_pu
    pullup (pad_a[i]);
    pullup (pad_b[i]);
    pullup (pad_c[i]);
  end

  bidir_bus_port #(.WIDTH(W), .SYNC_STAGES(S), .TURN_CYCLES(1), .STB_FILTER(F)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .pad(pad_a));
  bidir_bus_port #(.WIDTH(W), .SYNC_STAGES(S), .TURN_CYCLES(3), .STB_FILTER(F)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .pad(pad_b));
  bidir_bus_port #(.WIDTH(W), .SYNC_STAGES(S), .TURN_CYCLES(0), .STB_FILTER(F)) u_dut_c (
    .clk(clk), .rst(rst), .bus(bus_c.slave), .pad(pad_c));

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse;
  logic [W-1:0] last_cap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_watch();
    tick();
    if (bus_a.cap_valid === 1'b1) begin
      n_pulse++;
      last_cap = bus_a.cap_data;
    end
  endtask

  typedef struct {
    int         inst;
    logic       en;
    logic [7:0] data;
    logic       dir;
    logic       busy;
    logic [7:0] pad;   // 8'hFF means released
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int inst, logic en, logic [7:0] d, logic dir, logic busy, logic [7:0] p);
    vec_t v;
    v.inst = inst; v.en = en; v.data = d; v.dir = dir; v.busy = busy; v.pad = p;
    return v;
  endfunction

  task automatic drive(input int inst, input logic en, input logic [7:0] d);
    case (inst)
      0:       begin bus_a.drive_en = en; bus_a.drive_data = d; end
      1:       begin bus_b.drive_en = en; bus_b.drive_data = d; end
      default: begin bus_c.drive_en = en; bus_c.drive_data = d; end
    endcase
  endtask

  task automatic observe(input int inst, output logic dir, output logic busy, output logic [7:0] p);
    case (inst)
      0:       begin dir = bus_a.bus_dir; busy = bus_a.busy; p = pad_a; end
      1:       begin dir = bus_b.bus_dir; busy = bus_b.busy; p = pad_b; end
      default: begin dir = bus_c.bus_dir; busy = bus_c.busy; p = pad_c; end
    endcase
  endtask

  // Random run history, indexed by the edge that samples the value.
  logic         stb_h [N];
  logic [W-1:0] pad_h [N];
  logic [W-1:0] pad_init;

  function automatic logic get_stb(int idx);
    return (idx < 0) ? 1'b1 : stb_h[idx];
  endfunction

  function automatic logic [W-1:0] get_pad(int idx);
    return (idx < 0) ? pad_init : pad_h[idx];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a_dir, a_busy;
    logic [7:0] a_pad;
    logic       flt_m, flt_new, all_eq, rise;
    logic [W-1:0] cap_exp;

    rst = 1'b1;
    tb_pad_oe = 1'b1; tb_pad_val = 8'hA5;
    bus_a.strobe_n = 1'b1; bus_b.strobe_n = 1'b1; bus_c.strobe_n = 1'b1;
    drive(0, 1'b0, 8'h00); drive(1, 1'b0, 8'h00); drive(2, 1'b0, 8'h00);

    // ---- 1: reset ----
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst%0d_rd_data", i), bus_a.rd_data, 0);
      check($sformatf("rst%0d_cap_data", i), bus_a.cap_data, 0);
      check($sformatf("rst%0d_cap_valid", i), bus_a.cap_valid, 0);
      check($sformatf("rst%0d_bus_dir", i), bus_a.bus_dir, 0);
      check($sformatf("rst%0d_busy", i), bus_a.busy, 0);
      check($sformatf("rst%0d_pad", i), pad_a, 8'hA5);
    end
    rst = 1'b0;
    repeat (S) tick();
    check("rst_release_rd_data", bus_a.rd_data, 8'hA5);

    // ---- 4: capture ----
    tb_pad_val = 8'h5A;
    repeat (6) tick();
    n_pulse = 0; last_cap = '0;
    bus_a.strobe_n = 1'b0;
    repeat (6) tick_watch();
    bus_a.strobe_n = 1'b1;
    tick_watch();
    tb_pad_val = 8'hFF;
    repeat (12) tick_watch();
    check("cap_pulse_count", n_pulse, 1);
    check("cap_word", last_cap, 8'h5A);
    check("cap_data_held", bus_a.cap_data, 8'h5A);

    // ---- 5: glitch ----
    n_pulse = 0;
    bus_a.strobe_n = 1'b0;
    tick_watch();
    bus_a.strobe_n = 1'b1;
    repeat (10) tick_watch();
    check("glitch_pulse_count", n_pulse, 0);

    // ---- randomized input path and capture ----
    pad_init = W'($urandom);
    tb_pad_val = pad_init;
    repeat (6) tick();
    begin
      logic lvl;
      int   run;
      lvl = 1'b1; run = 0;
      for (int e = 0; e < N; e++) begin
        if (run == 0) begin
          lvl = ~lvl;
          run = $urandom_range(1, 6);
        end
        stb_h[e] = lvl;
        pad_h[e] = W'($urandom);
        run--;
      end
    end
    flt_m = 1'b1;
    cap_exp = 8'h5A;
    for (int e = 0; e < N; e++) begin
      bus_a.strobe_n = stb_h[e];
      tb_pad_val = pad_h[e];
      tick();
      all_eq = 1'b1;
      for (int j = e - S - F + 1; j <= e - S; j++)
        if (get_stb(j) != get_stb(e - S)) all_eq = 1'b0;
      flt_new = all_eq ? get_stb(e - S) : flt_m;
      rise = !flt_m && flt_new;
      flt_m = flt_new;
      if (rise) cap_exp = get_pad(e - S - F);
      check($sformatf("rnd%0d_rd_data", e), bus_a.rd_data, get_pad(e - S + 1));
      check($sformatf("rnd%0d_cap_valid", e), bus_a.cap_valid, rise);
      check($sformatf("rnd%0d_cap_data", e), bus_a.cap_data, cap_exp);
    end
    bus_a.strobe_n = 1'b1;
    repeat (6) tick();

    // ---- 2/3/7: direction FSM vectors ----
    tb_pad_oe = 1'b0;
    tick();
    // TURN_CYCLES = 1
    vt.push_back(mk(0, 1, 8'h3C, 0, 1, 8'hFF));
    vt.push_back(mk(0, 1, 8'h3C, 1, 0, 8'hFF));
    vt.push_back(mk(0, 1, 8'h3C, 1, 0, 8'h3C));
    vt.push_back(mk(0, 1, 8'hC3, 1, 0, 8'hC3));
    vt.push_back(mk(0, 0, 8'h11, 0, 1, 8'h11));
    vt.push_back(mk(0, 0, 8'h11, 0, 0, 8'hFF));
    vt.push_back(mk(0, 1, 8'h22, 0, 1, 8'hFF));
    vt.push_back(mk(0, 0, 8'h22, 0, 0, 8'hFF));
    vt.push_back(mk(0, 0, 8'h22, 0, 0, 8'hFF));
    vt.push_back(mk(0, 1, 8'h33, 0, 1, 8'hFF));
    vt.push_back(mk(0, 1, 8'h33, 1, 0, 8'hFF));
    vt.push_back(mk(0, 0, 8'h77, 0, 1, 8'h77));
    vt.push_back(mk(0, 1, 8'h77, 0, 0, 8'hFF));
    vt.push_back(mk(0, 1, 8'h77, 0, 1, 8'hFF));
    vt.push_back(mk(0, 0, 8'h77, 0, 0, 8'hFF));
    // TURN_CYCLES = 3: abort, full turn-out, TURN_IN ignores drive_en
    vt.push_back(mk(1, 1, 8'h3C, 0, 1, 8'hFF));
    vt.push_back(mk(1, 0, 8'h3C, 0, 0, 8'hFF));
    vt.push_back(mk(1, 0, 8'h3C, 0, 0, 8'hFF));
    vt.push_back(mk(1, 1, 8'h66, 0, 1, 8'hFF));
    vt.push_back(mk(1, 1, 8'h66, 0, 1, 8'hFF));
    vt.push_back(mk(1, 1, 8'h66, 0, 1, 8'hFF));
    vt.push_back(mk(1, 1, 8'h66, 1, 0, 8'hFF));
    vt.push_back(mk(1, 1, 8'h66, 1, 0, 8'h66));
    vt.push_back(mk(1, 0, 8'h24, 0, 1, 8'h24));
    vt.push_back(mk(1, 1, 8'h24, 0, 1, 8'hFF));
    vt.push_back(mk(1, 1, 8'h24, 0, 1, 8'hFF));
    vt.push_back(mk(1, 1, 8'h24, 0, 0, 8'hFF));
    vt.push_back(mk(1, 1, 8'h24, 0, 1, 8'hFF));
    vt.push_back(mk(1, 0, 8'h24, 0, 0, 8'hFF));
    // TURN_CYCLES = 0: no dead cycles either way
    vt.push_back(mk(2, 1, 8'h21, 1, 0, 8'hFF));
    vt.push_back(mk(2, 1, 8'h42, 1, 0, 8'h42));
    vt.push_back(mk(2, 0, 8'h18, 0, 0, 8'h18));
    vt.push_back(mk(2, 0, 8'h18, 0, 0, 8'hFF));

    foreach (vt[i]) begin
      drive(vt[i].inst, vt[i].en, vt[i].data);
      tick();
      observe(vt[i].inst, a_dir, a_busy, a_pad);
      check($sformatf("vec%0d_bus_dir", i), a_dir, vt[i].dir);
      check($sformatf("vec%0d_busy", i), a_busy, vt[i].busy);
      check($sformatf("vec%0d_pad", i), a_pad, vt[i].pad);
    end

    // ---- 6: strobe while driving gives no capture ----
    drive(0, 1'b1, 8'h0F);
    repeat (3) tick();
    n_pulse = 0;
    bus_a.strobe_n = 1'b0;
    repeat (4) tick_watch();
    bus_a.strobe_n = 1'b1;
    repeat (10) tick_watch();
    check("drive_cap_pulse_count", n_pulse, 0);
    check("drive_cap_bus_dir", bus_a.bus_dir, 1);
    check("drive_cap_pad", pad_a, 8'h0F);
    drive(0, 1'b0, 8'h0F);
    repeat (3) tick();

    // ---- 7: reset mid-DRIVE ----
    drive(0, 1'b1, 8'h5C);
    repeat (3) tick();
    check("pre_rst_pad", pad_a, 8'h5C);
    rst = 1'b1;
    tick();
    check("rst_drive_pad", pad_a, 8'hFF);
    check("rst_drive_bus_dir", bus_a.bus_dir, 0);
    check("rst_drive_busy", bus_a.busy, 0);
    drive(0, 1'b0, 8'h5C);
    rst = 1'b0;
    tick();
    check("post_rst_bus_dir", bus_a.bus_dir, 0);
    check("post_rst_pad", pad_a, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
